// File: rtl/spram_rr_arbiter_if.sv
// Bus bundle between the requesters, the round-robin arbiter and the shared RAM.
// The arbiter sits on the slave side. The requesters and the RAM model sit on the master side.
interface spram_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // Requester command ports
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wren;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;

    // Read responses
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    // RAM macro pins
    logic [ADDR_WIDTH-1:0]         ram_address;
    logic                          ram_wren;
    logic [DATA_WIDTH-1:0]         ram_data;
    logic [DATA_WIDTH-1:0]         ram_out;

    modport slave (
        input  req_valid, req_wren, req_lock, req_addr, req_wdata, ram_out,
        output req_ready, rsp_valid, rsp_rdata, ram_address, ram_wren, ram_data
    );

    modport master (
        output req_valid, req_wren, req_lock, req_addr, req_wdata, ram_out,
        input  req_ready, rsp_valid, rsp_rdata, ram_address, ram_wren, ram_data
    );
endinterface

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between NUM_REQ requesters.
// It supports bounded lock bursts, a registered issue stage, and a tag pipeline that
// routes read data back to the requester that issued the read.
module spram_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_HOLD    = 8
) (
    input logic                clk,
    input logic                reset,
    spram_rr_arbiter_if.slave  bus
);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int DEPTH  = 1 + RAM_LATENCY;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    typedef struct packed {
        logic               rd;
        logic [NUM_REQ-1:0] oh;
    } tag_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_owner;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_wren;
    logic [DATA_WIDTH-1:0] r_ram_data;
    tag_t                  r_tag [DEPTH];

    logic                  w_grant_vld;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_cand;
    logic [NUM_REQ-1:0]    w_grant_oh;
    logic                  w_sel_lock;
    logic                  w_sel_wren;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [HOLD_W-1:0]     w_hold_inc;

    // Wrap-around successor of a requester index.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) return '0;
        return p + 1'b1;
    endfunction

    // Pick the granted requester: a rotating search in IDLE, or the owner only in LOCKED.
    always_comb begin
        // NOTE: every variable gets a default up front so no path infers a latch.
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (reset) begin
            if (r_state == S_IDLE) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
                    if (!w_grant_vld && bus.req_valid[w_cand]) begin
                        w_grant_vld = 1'b1;
                        w_grant_idx = w_cand;
                    end
                end
            end else if (bus.req_valid[r_owner]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = r_owner;
            end
        end
    end

    assign w_grant_oh    = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign bus.req_ready = w_grant_oh;
    assign w_sel_lock    = bus.req_lock[w_grant_idx];
    assign w_sel_wren    = bus.req_wren[w_grant_idx];
    assign w_sel_addr    = bus.req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata   = bus.req_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_hold_inc    = r_hold_cnt + 1'b1;

    // Grant state machine: round-robin pointer, lock owner and burst length counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        if (w_sel_lock && MAX_HOLD > 1) begin
                            r_state    <= S_LOCKED;
                            r_owner    <= w_grant_idx;
                            r_hold_cnt <= HOLD_W'(1);
                        end else begin
                            r_ptr <= ptr_inc(w_grant_idx);
                        end
                    end
                end
                S_LOCKED: begin
                    // The tenure ends on an unlocked beat, on the hold cap, or when the owner goes idle.
                    if (!w_grant_vld || !w_sel_lock || int'(w_hold_inc) == MAX_HOLD) begin
                        r_state    <= S_IDLE;
                        r_ptr      <= ptr_inc(r_owner);
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= w_hold_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Issue stage: register the accepted command onto the RAM pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_addr <= '0;
            r_ram_wren <= 1'b0;
            r_ram_data <= '0;
        end else begin
            r_ram_wren <= w_grant_vld & w_sel_wren;
            if (w_grant_vld) begin
                r_ram_addr <= w_sel_addr;
                r_ram_data <= w_sel_wdata;
            end
        end
    end

    // Tag pipeline: follows each issued beat through the RAM latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the tag pipe is reset, unlike RAM contents, so in-flight reads are discarded.
            for (int s = 0; s < DEPTH; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0] <= tag_t'{rd: w_grant_vld & ~w_sel_wren, oh: w_grant_oh};
            for (int s = 1; s < DEPTH; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    assign bus.ram_address = r_ram_addr;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.ram_data    = r_ram_data;
    assign bus.rsp_valid   = r_tag[DEPTH-1].rd ? r_tag[DEPTH-1].oh : '0;
    assign bus.rsp_rdata   = r_tag[DEPTH-1].rd ? bus.ram_out : '0;
endmodule
